// File: rtl/baud_gen_frac.sv
`default_nettype none
// ============================================================================
// Module   : baud_gen_frac
// Purpose  : Fractional baud generator; optional bit enable via BAUD_GEN_FRAC_BIT_CE_EN
// Revision : 1.0
// ============================================================================
module baud_gen_frac #(
    parameter int FREQ_W     = 16,
    parameter int LIMIT_W    = 24,
    parameter int OVERSAMPLE = 16,
    parameter int DEF_FREQ   = 0,
    parameter int DEF_LIMIT  = 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [FREQ_W-1:0]             baud_freq,
    input  logic [LIMIT_W-1:0]            baud_limit,
    output logic                          ce_os,
    output logic                          ce_bit,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

    localparam int ACC_W = ((FREQ_W > LIMIT_W) ? FREQ_W : LIMIT_W) + 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);

    logic [FREQ_W-1:0]  freq_q, freq_d, sh_freq_q, sh_freq_d;
    logic [LIMIT_W-1:0] limit_q, limit_d, sh_limit_q, sh_limit_d;
    logic [ACC_W-1:0]   acc_q, acc_d, freq_ext, limit_ext;
    logic               pend_q, pend_d;
    logic               ce_os_q, ce_os_d;
    logic               hit, apply, accept;

    assign freq_ext  = ACC_W'(freq_q);
    assign limit_ext = ACC_W'(limit_q);
    assign hit       = enable && (acc_q >= limit_ext);
    assign accept    = cfg_valid && !pend_q;
    // Pending config lands on a tick boundary, or immediately while idle.
    assign apply     = pend_q && (hit || !enable);

    always_comb begin
        freq_d     = freq_q;
        limit_d    = limit_q;
        sh_freq_d  = sh_freq_q;
        sh_limit_d = sh_limit_q;
        pend_d     = pend_q;
        acc_d      = acc_q;
        ce_os_d    = hit;
        if (accept) begin
            sh_freq_d  = baud_freq;
            sh_limit_d = baud_limit;
            pend_d     = 1'b1;
        end
        if (apply) begin
            freq_d  = sh_freq_q;
            limit_d = sh_limit_q;
            pend_d  = 1'b0;
        end
        if (!enable) begin
            acc_d = '0;
        end else if (hit) begin
            acc_d = apply ? '0 : (acc_q - limit_ext);
        end else begin
            acc_d = acc_q + freq_ext;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            freq_q     <= FREQ_W'(DEF_FREQ);
            limit_q    <= LIMIT_W'(DEF_LIMIT);
            sh_freq_q  <= '0;
            sh_limit_q <= '0;
            pend_q     <= 1'b0;
            acc_q      <= '0;
            ce_os_q    <= 1'b0;
        end else begin
            freq_q     <= freq_d;
            limit_q    <= limit_d;
            sh_freq_q  <= sh_freq_d;
            sh_limit_q <= sh_limit_d;
            pend_q     <= pend_d;
            acc_q      <= acc_d;
            ce_os_q    <= ce_os_d;
        end
    end

    assign cfg_ready = !pend_q;
    assign ce_os     = ce_os_q;

`ifdef BAUD_GEN_FRAC_BIT_CE_EN
    logic [OS_W-1:0] os_cnt_q, os_cnt_d;
    logic            ce_bit_q, ce_bit_d;

    // ce_bit uses the pre-apply count; the counter itself restarts on apply.
    always_comb begin
        os_cnt_d = os_cnt_q;
        ce_bit_d = 1'b0;
        if (!enable) begin
            os_cnt_d = '0;
        end else if (hit) begin
            ce_bit_d = (os_cnt_q == OS_W'(OVERSAMPLE - 1));
            if (apply || ce_bit_d) begin
                os_cnt_d = '0;
            end else begin
                os_cnt_d = os_cnt_q + OS_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            os_cnt_q <= '0;
            ce_bit_q <= 1'b0;
        end else begin
            os_cnt_q <= os_cnt_d;
            ce_bit_q <= ce_bit_d;
        end
    end

    assign ce_bit   = ce_bit_q;
    assign os_phase = os_cnt_q;
`else
    assign ce_bit   = 1'b0;
    assign os_phase = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_baud_gen_frac.sv
`default_nettype none
// ============================================================================
// Module   : tb_baud_gen_frac
// Purpose  : Directed vector bench for baud_gen_frac (with or without BAUD_GEN_FRAC_BIT_CE_EN)
// Revision : 1.0
// ============================================================================
module tb_baud_gen_frac;

`ifdef BAUD_GEN_FRAC_BIT_CE_EN
    localparam bit BITCE = 1'b1;
`else
    localparam bit BITCE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] baud_freq = '0;
    logic [23:0] baud_limit = '0;
    logic        cfg_ready, ce_os, ce_bit;
    logic [3:0]  os_phase;

    baud_gen_frac dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .baud_freq  (baud_freq),
        .baud_limit (baud_limit),
        .ce_os      (ce_os),
        .ce_bit     (ce_bit),
        .os_phase   (os_phase)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic        vld;
        logic [15:0] f;
        logic [23:0] l;
        logic        os;
        logic        eb;
        logic        rdy;
        logic [3:0]  ph;
    } vec_t;

    vec_t tbl [30];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sv(input int i, input logic en, input logic vld, input logic [15:0] f,
                      input logic [23:0] l, input logic os, input logic eb, input logic rdy,
                      input logic [3:0] ph);
        tbl[i] = '{en, vld, f, l, os, eb, rdy, ph};
    endtask

    task automatic cfg_idle(input logic [15:0] f, input logic [23:0] l);
        enable     = 1'b0;
        cfg_valid  = 1'b1;
        baud_freq  = f;
        baud_limit = l;
        tick();
        cfg_valid = 1'b0;
        tick();
        chk("cfg_idle_ready", 32'(cfg_ready), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        enable  = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        #4;
    endtask

    initial begin
        int cnt_os, cnt_bit, bad, waited;
        logic [3:0] prev_ph;

        // Fill vector table: inputs applied, outputs sampled after the next edge.
        sv(0,  0, 1, 16'd1, 24'd2, 0, 0, 0, 0);
        sv(1,  0, 0, 16'd0, 24'd0, 0, 0, 1, 0);
        sv(2,  1, 0, 16'd0, 24'd0, 0, 0, 1, 0);
        sv(3,  1, 0, 16'd0, 24'd0, 0, 0, 1, 0);
        sv(4,  1, 0, 16'd0, 24'd0, 1, 0, 1, 1);
        sv(5,  1, 0, 16'd0, 24'd0, 0, 0, 1, 1);
        sv(6,  1, 0, 16'd0, 24'd0, 0, 0, 1, 1);
        sv(7,  1, 0, 16'd0, 24'd0, 1, 0, 1, 2);
        sv(8,  1, 1, 16'd1, 24'd0, 0, 0, 0, 2);
        sv(9,  1, 1, 16'd3, 24'd5, 0, 0, 0, 2);
        sv(10, 1, 1, 16'd3, 24'd5, 1, 0, 1, 0);
        sv(11, 1, 0, 16'd0, 24'd0, 1, 0, 1, 1);
        for (int i = 12; i <= 25; i++) sv(i, 1, 0, 16'd0, 24'd0, 1, 0, 1, 4'(i - 10));
        sv(26, 1, 0, 16'd0, 24'd0, 1, 1, 1, 0);
        sv(27, 1, 0, 16'd0, 24'd0, 1, 0, 1, 1);
        sv(28, 0, 0, 16'd0, 24'd0, 0, 0, 1, 0);
        sv(29, 1, 0, 16'd0, 24'd0, 1, 0, 1, 1);

        // Reset state
        #12;
        chk("rst_ce_os", 32'(ce_os), 32'd0);
        chk("rst_ce_bit", 32'(ce_bit), 32'd0);
        chk("rst_os_phase", 32'(os_phase), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);

        // Defaults: enabled but silent
        @(negedge clock);
        reset_n = 1'b1;
        enable  = 1'b1;
        cnt_os = 0; cnt_bit = 0; bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ce_os) cnt_os++;
            if (ce_bit) cnt_bit++;
            if (!cfg_ready) bad++;
        end
        chk("dflt_ce_os_count", 32'(cnt_os), 32'd0);
        chk("dflt_ce_bit_count", 32'(cnt_bit), 32'd0);
        chk("dflt_not_ready_count", 32'(bad), 32'd0);

        // Table-driven vectors
        do_reset();
        for (int i = 0; i < 30; i++) begin
            enable     = tbl[i].en;
            cfg_valid  = tbl[i].vld;
            baud_freq  = tbl[i].f;
            baud_limit = tbl[i].l;
            tick();
            chk($sformatf("vec%0d_ce_os", i), 32'(ce_os), 32'(tbl[i].os));
            chk($sformatf("vec%0d_ce_bit", i), 32'(ce_bit), BITCE ? 32'(tbl[i].eb) : 32'd0);
            chk($sformatf("vec%0d_ready", i), 32'(cfg_ready), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d_phase", i), 32'(os_phase), BITCE ? 32'(tbl[i].ph) : 32'd0);
        end
        cfg_valid = 1'b0;

        // 50 MHz / 115200 baud over one full accumulator period
        cfg_idle(16'd1152, 24'd30098);
        enable = 1'b1;
        cnt_os = 0; cnt_bit = 0; bad = 0;
        prev_ph = os_phase;
        for (int i = 0; i < 31250; i++) begin
            tick();
            if (ce_os) cnt_os++;
            if (ce_bit) cnt_bit++;
            if (ce_bit && (!ce_os || prev_ph != 4'd15)) bad++;
            if (!BITCE && (ce_bit || os_phase != 4'd0)) bad++;
            prev_ph = os_phase;
        end
        chk("baud_ce_os_count", 32'(cnt_os), 32'd1152);
        chk("baud_ce_bit_count", 32'(cnt_bit), BITCE ? 32'd72 : 32'd0);
        chk("baud_bit_alignment_errors", 32'(bad), 32'd0);

        // freq=1, limit=1 toggles with period 2
        cfg_idle(16'd1, 24'd1);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("toggle%0d", i), 32'(ce_os), 32'(i % 2));
        end
        // Runtime switch to limit=0 lands on the next hit
        cfg_valid  = 1'b1;
        baud_freq  = 16'd0;
        baud_limit = 24'd0;
        tick();
        cfg_valid = 1'b0;
        chk("switch_ready_low", 32'(cfg_ready), 32'd0);
        waited = 0;
        while (!cfg_ready && waited < 10) begin
            tick();
            waited++;
        end
        chk("switch_apply_timeout", 32'(cfg_ready), 32'd1);
        chk("switch_apply_pulse", 32'(ce_os), 32'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!ce_os) bad++;
        end
        chk("limit0_gaps", 32'(bad), 32'd0);

        // Asynchronous reset between edges
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_ce_os", 32'(ce_os), 32'd0);
        chk("async_ce_bit", 32'(ce_bit), 32'd0);
        chk("async_phase", 32'(os_phase), 32'd0);
        chk("async_ready", 32'(cfg_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        cnt_os = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ce_os) cnt_os++;
        end
        chk("async_dflt_ce_os_count", 32'(cnt_os), 32'd0);

        // freq=0 stall: pending config waits until enable drops
        cfg_valid  = 1'b1;
        baud_freq  = 16'd1;
        baud_limit = 24'd1;
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("stall_still_pending", 32'(cfg_ready), 32'd0);
        chk("stall_no_ce_os", 32'(ce_os), 32'd0);
        enable = 1'b0;
        tick();
        chk("stall_apply_on_disable", 32'(cfg_ready), 32'd1);
        enable = 1'b1;
        tick();
        chk("stall_first_ce_os", 32'(ce_os), 32'd0);
        tick();
        chk("stall_second_ce_os", 32'(ce_os), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
